// File: rtl/nexys_starship_monster_bank.sv
// Multi-terminal monster manager: per-terminal spawn/timeout tracking, spawn cap,
// and a global INIT/PLAY/OVER state machine, all advanced by a one-cycle timer_tick.
module nexys_starship_monster_bank #(
  parameter int NUM_TERM    = 4,
  parameter int TIMER_W     = 8,
  parameter int TIMEOUT     = 12,
  parameter int SPAWN_DELAY = 1,
  parameter int MAX_ACTIVE  = NUM_TERM
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                timer_tick,
  input  logic                play_flag,
  input  logic [NUM_TERM-1:0] random,
  input  logic [NUM_TERM-1:0] kill,
  output logic [NUM_TERM-1:0] monster,
  output logic                gameover,
  output logic [2:0]          expired_idx,
  output logic [3:0]          active_count,
  output logic                q_Init,
  output logic                q_Play,
  output logic                q_Over
);

  // One-hot encoding lets the q_* outputs come straight from the state flops.
  typedef enum logic [2:0] {
    S_INIT = 3'b001,
    S_PLAY = 3'b010,
    S_OVER = 3'b100
  } state_t;

  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] DELAY_MAX  = TIMER_W'(SPAWN_DELAY);
  localparam logic [3:0]         CAP        = 4'(MAX_ACTIVE);

  state_t               state_q, state_d;
  logic [NUM_TERM-1:0]  monster_d;
  logic [TIMER_W-1:0]   timer_q [NUM_TERM];
  logic [TIMER_W-1:0]   timer_d [NUM_TERM];
  logic [TIMER_W-1:0]   delay_q [NUM_TERM];
  logic [TIMER_W-1:0]   delay_d [NUM_TERM];
  logic [2:0]           idx_d;
  logic [3:0]           count_d;
  logic [NUM_TERM-1:0]  arm, expire, cand, grant;

  // Per-terminal status and the ascending-priority spawn grant under the cap.
  always_comb begin
    logic [3:0] used;
    arm    = '0;
    expire = '0;
    cand   = '0;
    grant  = '0;
    // NOTE: 'used' is a running total inside one combinational pass, so it is
    // assigned with '=' and each iteration sees the previous grants.
    used   = active_count;
    for (int i = 0; i < NUM_TERM; i++) begin
      arm[i]    = (delay_q[i] >= DELAY_MAX);
      expire[i] = monster[i] & timer_tick & (timer_q[i] == TIMER_LAST) & ~kill[i];
      cand[i]   = ~monster[i] & arm[i] & random[i] & ~kill[i];
      if (cand[i] && (used < CAP)) begin
        grant[i] = 1'b1;
        used     = used + 4'd1;
      end
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a hold value first, so no path
    // through the case below can infer a latch.
    state_d   = state_q;
    monster_d = monster;
    timer_d   = timer_q;
    delay_d   = delay_q;
    idx_d     = expired_idx;
    count_d   = '0;

    unique case (state_q)
      S_INIT: begin
        if (play_flag) state_d = S_PLAY;
      end
      S_PLAY: begin
        if (!play_flag) begin
          state_d   = S_INIT;
          monster_d = '0;
          for (int i = 0; i < NUM_TERM; i++) begin
            timer_d[i] = '0;
            delay_d[i] = '0;
          end
        end else if (|expire) begin
          // Terminals are frozen on the expiry edge; only the culprit is recorded.
          state_d = S_OVER;
          for (int i = NUM_TERM - 1; i >= 0; i--)
            if (expire[i]) idx_d = 3'(i);
        end else begin
          for (int i = 0; i < NUM_TERM; i++) begin
            if (monster[i]) begin
              if (kill[i]) begin
                monster_d[i] = 1'b0;
                timer_d[i]   = '0;
                delay_d[i]   = '0;
              end else if (timer_tick) begin
                timer_d[i] = timer_q[i] + TIMER_W'(1);
              end
            end else if (grant[i]) begin
              monster_d[i] = 1'b1;
              timer_d[i]   = '0;
              delay_d[i]   = '0;
            end else if (timer_tick && !arm[i]) begin
              delay_d[i] = delay_q[i] + TIMER_W'(1);
            end
          end
        end
      end
      S_OVER: begin
        if (!play_flag) begin
          state_d   = S_INIT;
          monster_d = '0;
          for (int i = 0; i < NUM_TERM; i++) begin
            timer_d[i] = '0;
            delay_d[i] = '0;
          end
        end
      end
      default: state_d = S_INIT;
    endcase

    for (int i = 0; i < NUM_TERM; i++)
      count_d = count_d + 4'(monster_d[i]);
  end

  // NOTE: reset is synchronous, so it lives inside the clocked branch and the
  // small counter arrays are cleared explicitly alongside the other state.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= S_INIT;
      monster      <= '0;
      expired_idx  <= '0;
      active_count <= '0;
      for (int i = 0; i < NUM_TERM; i++) begin
        timer_q[i] <= '0;
        delay_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      monster      <= monster_d;
      expired_idx  <= idx_d;
      active_count <= count_d;
      for (int i = 0; i < NUM_TERM; i++) begin
        timer_q[i] <= timer_d[i];
        delay_q[i] <= delay_d[i];
      end
    end
  end

  assign gameover = (state_q == S_OVER);
  assign q_Init   = state_q[0];
  assign q_Play   = state_q[1];
  assign q_Over   = state_q[2];

endmodule

// File: tb/tb_nexys_starship_monster_bank.sv
// Bench for nexys_starship_monster_bank (MAX_ACTIVE=2): directed vector table
// plus randomized traffic compared every cycle against a behavioural model.
module tb_nexys_starship_monster_bank;

  localparam int N        = 4;
  localparam int TIMEOUT  = 12;
  localparam int SDELAY   = 1;
  localparam int CAP      = 2;

  logic         Clk = 1'b0;
  logic         Reset, timer_tick, play_flag;
  logic [N-1:0] random, kill;
  logic [N-1:0] monster;
  logic         gameover;
  logic [2:0]   expired_idx;
  logic [3:0]   active_count;
  logic         q_Init, q_Play, q_Over;

  int checks = 0;
  int errors = 0;

  // Reference model: plain integers per terminal.
  int m_state;          // 1 = INIT, 2 = PLAY, 4 = OVER
  int m_idx;
  int m_mon   [N];
  int m_age   [N];      // ticks since spawn
  int m_empty [N];      // ticks spent empty since last clear

  nexys_starship_monster_bank #(
    .NUM_TERM(N), .TIMER_W(8), .TIMEOUT(TIMEOUT), .SPAWN_DELAY(SDELAY), .MAX_ACTIVE(CAP)
  ) dut (
    .Clk(Clk), .Reset(Reset), .timer_tick(timer_tick), .play_flag(play_flag),
    .random(random), .kill(kill), .monster(monster), .gameover(gameover),
    .expired_idx(expired_idx), .active_count(active_count),
    .q_Init(q_Init), .q_Play(q_Play), .q_Over(q_Over)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    bit         rst;
    bit         play;
    bit         tick;
    logic [3:0] rnd;
    logic [3:0] kil;
    int         reps;
    logic [3:0] mon;
    bit         go;
    logic [2:0] idx;
    logic [3:0] cnt;
    logic [2:0] st;   // {q_Over, q_Play, q_Init}
  } vec_t;

  vec_t vecs [$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      m_mon[i] = 0; m_age[i] = 0; m_empty[i] = 0;
    end
  endtask

  task automatic model_step(input bit r, input bit p, input bit t,
                            input logic [3:0] rn, input logic [3:0] k);
    int first, cur, granted;
    if (r) begin
      m_state = 1; m_idx = 0; model_clear();
    end else if (m_state == 1) begin
      if (p) m_state = 2;
    end else if (m_state == 2) begin
      first = -1;
      for (int i = 0; i < N; i++)
        if (first < 0 && m_mon[i] == 1 && t && m_age[i] == TIMEOUT - 1 && !k[i]) first = i;
      if (!p) begin
        m_state = 1; model_clear();
      end else if (first >= 0) begin
        m_state = 4; m_idx = first;
      end else begin
        cur = 0; granted = 0;
        for (int i = 0; i < N; i++) cur += m_mon[i];
        for (int i = 0; i < N; i++) begin
          if (m_mon[i] == 1) begin
            if (k[i]) begin m_mon[i] = 0; m_age[i] = 0; m_empty[i] = 0; end
            else if (t) m_age[i]++;
          end else if (m_empty[i] >= SDELAY && rn[i] && !k[i] && cur + granted < CAP) begin
            m_mon[i] = 1; m_age[i] = 0; m_empty[i] = 0; granted++;
          end else if (t && m_empty[i] < SDELAY) begin
            m_empty[i]++;
          end
        end
      end
    end else begin
      if (!p) begin m_state = 1; model_clear(); end
    end
  endtask

  function automatic logic [3:0] model_mon();
    logic [3:0] v = '0;
    for (int i = 0; i < N; i++) v[i] = (m_mon[i] == 1);
    return v;
  endfunction

  // Apply one cycle of inputs, advance the model, sample 1 time unit after the edge.
  task automatic step(input bit r, input bit p, input bit t,
                      input logic [3:0] rn, input logic [3:0] k);
    logic [3:0] mv;
    int cnt;
    Reset = r; play_flag = p; timer_tick = t; random = rn; kill = k;
    model_step(r, p, t, rn, k);
    @(posedge Clk);
    #1;
    mv = model_mon();
    cnt = 0;
    for (int i = 0; i < N; i++) cnt += m_mon[i];
    check("model monster", monster, mv);
    check("model gameover", gameover, (m_state == 4));
    check("model expired_idx", expired_idx, m_idx);
    check("model active_count", active_count, cnt);
    check("model state", {q_Over, q_Play, q_Init}, m_state);
  endtask

  task automatic add(input bit rst, input bit play, input bit tick, input logic [3:0] rnd,
                     input logic [3:0] kil, input int reps, input logic [3:0] mon, input bit go,
                     input logic [2:0] idx, input logic [3:0] cnt, input logic [2:0] st);
    vec_t v;
    v.rst = rst; v.play = play; v.tick = tick; v.rnd = rnd; v.kil = kil; v.reps = reps;
    v.mon = mon; v.go = go; v.idx = idx; v.cnt = cnt; v.st = st;
    vecs.push_back(v);
  endtask

  initial begin
    Reset = 1'b1; play_flag = 1'b0; timer_tick = 1'b0; random = '0; kill = '0;
    m_state = 1; m_idx = 0; model_clear();

    //  rst play tick rnd      kill     reps mon      go idx cnt st
    // Reset with all spawn requests high.
    add(1, 0, 0, 4'hF,    4'h0,    2,  4'b0000, 0, 0, 0, 3'b001);
    // Single spawn on terminal 2 and a full 12-tick timeout.
    add(0, 1, 0, 4'h0,    4'h0,    1,  4'b0000, 0, 0, 0, 3'b010);
    add(0, 1, 1, 4'h0,    4'h0,    1,  4'b0000, 0, 0, 0, 3'b010);
    add(0, 1, 0, 4'b0100, 4'h0,    1,  4'b0100, 0, 0, 1, 3'b010);
    add(0, 1, 1, 4'h0,    4'h0,    11, 4'b0100, 0, 0, 1, 3'b010);
    add(0, 1, 1, 4'h0,    4'h0,    1,  4'b0100, 1, 2, 1, 3'b100);
    add(0, 1, 1, 4'hF,    4'hF,    2,  4'b0100, 1, 2, 1, 3'b100);
    add(0, 0, 0, 4'h0,    4'h0,    1,  4'b0000, 0, 2, 0, 3'b001);
    // Kill on the expiring tick wins; re-spawn waits one tick.
    add(0, 1, 0, 4'h0,    4'h0,    1,  4'b0000, 0, 2, 0, 3'b010);
    add(0, 1, 1, 4'h0,    4'h0,    1,  4'b0000, 0, 2, 0, 3'b010);
    add(0, 1, 0, 4'b0001, 4'h0,    1,  4'b0001, 0, 2, 1, 3'b010);
    add(0, 1, 1, 4'h0,    4'h0,    11, 4'b0001, 0, 2, 1, 3'b010);
    add(0, 1, 1, 4'h0,    4'b0001, 1,  4'b0000, 0, 2, 0, 3'b010);
    add(0, 1, 0, 4'b0001, 4'h0,    2,  4'b0000, 0, 2, 0, 3'b010);
    add(0, 1, 1, 4'b0001, 4'h0,    1,  4'b0000, 0, 2, 0, 3'b010);
    add(0, 1, 0, 4'b0001, 4'h0,    1,  4'b0001, 0, 2, 1, 3'b010);
    // Spawn cap of two: ascending grant, then re-arm after kill.
    add(0, 1, 0, 4'hF,    4'h0,    1,  4'b0011, 0, 2, 2, 3'b010);
    add(0, 1, 0, 4'h0,    4'b0010, 1,  4'b0001, 0, 2, 1, 3'b010);
    add(0, 1, 0, 4'b0110, 4'h0,    1,  4'b0101, 0, 2, 2, 3'b010);
    add(0, 1, 0, 4'h0,    4'b0101, 1,  4'b0000, 0, 2, 0, 3'b010);
    add(0, 1, 1, 4'h0,    4'h0,    1,  4'b0000, 0, 2, 0, 3'b010);
    add(0, 1, 0, 4'b0010, 4'h0,    1,  4'b0010, 0, 2, 1, 3'b010);
    // Terminals 1 and 3 expire together; lowest index reported.
    add(0, 1, 0, 4'b1000, 4'h0,    1,  4'b1010, 0, 2, 2, 3'b010);
    add(0, 1, 1, 4'h0,    4'h0,    11, 4'b1010, 0, 2, 2, 3'b010);
    add(0, 1, 1, 4'h0,    4'h0,    1,  4'b1010, 1, 1, 2, 3'b100);
    add(0, 0, 0, 4'h0,    4'h0,    1,  4'b0000, 0, 1, 0, 3'b001);
    // Reset mid-play, then a full-length timeout afterwards.
    add(0, 1, 0, 4'h0,    4'h0,    1,  4'b0000, 0, 1, 0, 3'b010);
    add(0, 1, 1, 4'h0,    4'h0,    1,  4'b0000, 0, 1, 0, 3'b010);
    add(0, 1, 0, 4'b1010, 4'h0,    1,  4'b1010, 0, 1, 2, 3'b010);
    add(0, 1, 1, 4'h0,    4'h0,    3,  4'b1010, 0, 1, 2, 3'b010);
    add(1, 1, 1, 4'hF,    4'h0,    1,  4'b0000, 0, 0, 0, 3'b001);
    add(0, 1, 0, 4'h0,    4'h0,    1,  4'b0000, 0, 0, 0, 3'b010);
    add(0, 1, 1, 4'h0,    4'h0,    1,  4'b0000, 0, 0, 0, 3'b010);
    add(0, 1, 0, 4'b1010, 4'h0,    1,  4'b1010, 0, 0, 2, 3'b010);
    add(0, 1, 1, 4'h0,    4'h0,    11, 4'b1010, 0, 0, 2, 3'b010);
    add(0, 1, 1, 4'h0,    4'h0,    1,  4'b1010, 1, 1, 2, 3'b100);
    add(0, 0, 0, 4'h0,    4'h0,    1,  4'b0000, 0, 1, 0, 3'b001);

    for (int v = 0; v < vecs.size(); v++) begin
      for (int r = 0; r < vecs[v].reps; r++) begin
        step(vecs[v].rst, vecs[v].play, vecs[v].tick, vecs[v].rnd, vecs[v].kil);
        check($sformatf("vec%0d monster", v), monster, vecs[v].mon);
        check($sformatf("vec%0d gameover", v), gameover, vecs[v].go);
        check($sformatf("vec%0d expired_idx", v), expired_idx, vecs[v].idx);
        check($sformatf("vec%0d active_count", v), active_count, vecs[v].cnt);
        check($sformatf("vec%0d state", v), {q_Over, q_Play, q_Init}, vecs[v].st);
      end
    end

    // Randomized traffic against the reference model.
    step(1, 0, 0, 4'h0, 4'h0);
    for (int c = 0; c < 3000; c++) begin
      logic [3:0] k;
      for (int i = 0; i < N; i++) k[i] = ($urandom_range(0, 7) == 0);
      step(($urandom_range(0, 999) == 0),
           ($urandom_range(0, 99) >= 2),
           1'($urandom_range(0, 1)),
           4'($urandom),
           k);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
